// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes host words MSB-first onto a ccff chain.
// Optional readback/CRC check is compiled in with `define CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 18
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SHIFT  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_reg;
  logic [WORD_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [WB_W-1:0]   word_bit_reg;

`ifdef CCFF_READBACK_EN
  logic [7:0] crc_wr_reg;
  logic [7:0] crc_rd_reg;
  logic       cfg_err_reg;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  assign cfg_err = cfg_err_reg;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign cfg_err     = 1'b0;
`endif

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      bit_cnt_reg  <= '0;
      word_bit_reg <= '0;
`ifdef CCFF_READBACK_EN
      crc_wr_reg   <= '0;
      crc_rd_reg   <= '0;
      cfg_err_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            bit_cnt_reg <= '0;
`ifdef CCFF_READBACK_EN
            crc_wr_reg  <= '0;
            crc_rd_reg  <= '0;
            cfg_err_reg <= 1'b0;
`endif
            state_reg   <= FETCH;
          end
        end
        FETCH: begin
          if (cfg_valid) begin
            shreg_reg    <= cfg_data;
            word_bit_reg <= '0;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_reg    <= {shreg_reg[WORD_W-2:0], 1'b0};
          bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
          word_bit_reg <= word_bit_reg + WB_W'(1);
`ifdef CCFF_READBACK_EN
          crc_wr_reg   <= crc8_step(crc_wr_reg, shreg_reg[WORD_W-1]);
`endif
          // Low bits left in the final word are simply dropped here.
          if (bit_cnt_reg == LAST_BIT) begin
`ifdef CCFF_READBACK_EN
            bit_cnt_reg <= '0;
            state_reg   <= VERIFY;
`else
            state_reg   <= DONE;
`endif
          end else if (word_bit_reg == LAST_WB) begin
            state_reg <= FETCH;
          end
        end
`ifdef CCFF_READBACK_EN
        VERIFY: begin
          // bit_cnt is reused to time one full recirculation of the chain.
          crc_rd_reg  <= crc8_step(crc_rd_reg, ccff_tail);
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == LAST_BIT) begin
            state_reg <= DONE;
          end
        end
`endif
        DONE: begin
`ifdef CCFF_READBACK_EN
          cfg_err_reg <= (crc_rd_reg != crc_wr_reg);
`endif
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Decoded from registered state only so a downstream clock-gate latch sees no glitches.
  assign cfg_ready = (state_reg == FETCH);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign ccff_en   = (state_reg == SHIFT) || (state_reg == VERIFY);

  always_comb begin
    ccff_head = 1'b0;
    if (state_reg == SHIFT) begin
      ccff_head = shreg_reg[WORD_W-1];
    end
`ifdef CCFF_READBACK_EN
    else if (state_reg == VERIFY) begin
      ccff_head = ccff_tail;
    end
`endif
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader against a timeline/chain reference model.
// Honours `define CCFF_READBACK_EN the same way as the design.
module tb_ccff_chain_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 18;
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CCFF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef logic [WORD_W-1:0] word_t;

  logic              prog_clk;
  logic              prog_rst_n;
  logic              start;
  word_t             cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              cfg_err;

  logic [CHAIN_LEN-1:0] chain;
  bit                   stuck;
  bit                   prev_err;
  int                   tests;
  int                   failures;

  ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .start     (start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .ccff_head (ccff_head),
    .ccff_en   (ccff_en),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Behavioural configuration chain hanging off the loader.
  always @(posedge prog_clk) begin
    if (ccff_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = stuck ? 1'b0 : chain[CHAIN_LEN-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [7:0] crc8(input bit b [CHAIN_LEN]);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic run_load(input word_t w [NW], input int st [NW], input bit stk,
                          input bit pulse_shift, input bit pulse_done,
                          input int fixed_done, input int id);
    bit bits  [CHAIN_LEN];
    bit rbits [CHAIN_LEN];
    logic [127:0] e_ready, e_en, e_head, e_busy, e_done, e_err;
    logic [127:0] o_ready, o_en, o_head, o_busy, o_done, o_err;
    logic [CHAIN_LEN-1:0] e_chain;
    int c, k, nb, done_c, obs_done, wi, wait_cnt, first_shift;
    bit new_err;

    // Reference timeline: fetch bubble + optional host stall per word, then shift.
    for (int i = 0; i < CHAIN_LEN; i++) begin
      bits[i]  = w[i / WORD_W][WORD_W - 1 - (i % WORD_W)];
      rbits[i] = stk ? 1'b0 : bits[i];
    end
    e_ready = '0; e_en = '0; e_head = '0; e_busy = '0; e_done = '0; e_err = '0;
    c = 1; k = 0;
    first_shift = 2 + st[0];
    for (int i = 0; i < NW; i++) begin
      for (int s = 0; s <= st[i]; s++) e_ready[c + s] = 1'b1;
      c = c + st[i];
      nb = CHAIN_LEN - i * WORD_W;
      if (nb > WORD_W) nb = WORD_W;
      for (int j = 1; j <= nb; j++) begin
        e_en[c + j]   = 1'b1;
        e_head[c + j] = bits[k];
        k++;
      end
      c = c + nb + 1;
    end
    if (RB) begin
      for (int j = 0; j < CHAIN_LEN; j++) begin
        e_en[c + j]   = 1'b1;
        e_head[c + j] = rbits[j];
      end
      c = c + CHAIN_LEN;
    end
    done_c = c;
    e_done[done_c] = 1'b1;
    for (int j = 1; j <= done_c; j++) e_busy[j] = 1'b1;
    new_err = RB && (crc8(bits) != crc8(rbits));
    e_err[0] = prev_err;
    e_err[done_c + 1] = new_err;
    for (int i = 0; i < CHAIN_LEN; i++) e_chain[CHAIN_LEN - 1 - i] = (RB && stk) ? 1'b0 : bits[i];

    stuck = stk;
    // A stray cfg_valid while idle must not start anything.
    start = 1'b0; cfg_valid = 1'b1; cfg_data = word_t'($urandom);
    step();
    check("idle_valid", 128'({busy, cfg_ready, ccff_en, done}), 128'(0));

    o_ready = '0; o_en = '0; o_head = '0; o_busy = '0; o_done = '0; o_err = '0;
    wi = 0; wait_cnt = st[0]; obs_done = -1;
    for (int cyc = 0; cyc <= done_c + 1; cyc++) begin
      o_ready[cyc] = cfg_ready;
      o_en[cyc]    = ccff_en;
      o_head[cyc]  = ccff_head;
      o_busy[cyc]  = busy;
      o_done[cyc]  = done;
      o_err[cyc]   = cfg_err;
      if (done && obs_done < 0) obs_done = cyc;
      start = (cyc == 0) || (pulse_shift && cyc == first_shift) || (pulse_done && cyc == done_c);
      if (wi < NW) begin
        if (wait_cnt == 0) begin
          cfg_valid = 1'b1;
          cfg_data  = w[wi];
        end else begin
          cfg_valid = 1'b0;
          cfg_data  = word_t'($urandom);
          if (cfg_ready) wait_cnt--;
        end
        if (cfg_valid && cfg_ready) begin
          wi++;
          wait_cnt = (wi < NW) ? st[wi] : 0;
        end
      end else begin
        cfg_valid = 1'b0;
      end
      step();
    end
    start = 1'b0; cfg_valid = 1'b0;

    check("cfg_ready", o_ready, e_ready);
    check("ccff_en",   o_en,    e_en);
    check("ccff_head", o_head,  e_head);
    check("busy",      o_busy,  e_busy);
    check("done",      o_done,  e_done);
    check("cfg_err",   o_err,   e_err);
    check("chain",     128'(chain), 128'(e_chain));
    if (fixed_done >= 0) check("done_cycle", 128'(obs_done), 128'(fixed_done));
    prev_err = new_err;
    $display("[TB] load %0d: done at cycle %0d, cfg_err=%0b, chain=%h", id, obs_done, cfg_err, chain);
  endtask

  initial begin
    word_t w  [NW];
    int    st [NW];
    tests = 0; failures = 0;
    prog_rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    stuck = 1'b0; prev_err = 1'b0; chain = '0;
    step(); step();
    check("reset_outputs", 128'({cfg_ready, ccff_en, ccff_head, busy, done, cfg_err}), 128'(0));
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    step();

    w[0] = word_t'('hA5); w[1] = word_t'('h3C); w[2] = word_t'('hC0);
    st[0] = 0; st[1] = 0; st[2] = 0;
    run_load(w, st, 1'b0, 1'b0, 1'b0, RB ? 40 : 22, 0);
    st[1] = 5;
    run_load(w, st, 1'b0, 1'b0, 1'b0, RB ? 45 : 27, 1);
    st[1] = 0;
    run_load(w, st, 1'b1, 1'b0, 1'b0, -1, 2);
    run_load(w, st, 1'b0, 1'b0, 1'b0, -1, 3);
    run_load(w, st, 1'b0, 1'b1, 1'b1, -1, 4);

    // Reset in the middle of the second word.
    start = 1'b1; cfg_valid = 1'b1; cfg_data = word_t'('h5A);
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("pre_reset_en", 128'({busy, ccff_en}), 128'(3));
    #2 prog_rst_n = 1'b0;
    #1 check("async_reset", 128'({cfg_ready, ccff_en, ccff_head, busy, done, cfg_err}), 128'(0));
    cfg_valid = 1'b0;
    step();
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    prev_err = 1'b0;
    step();
    run_load(w, st, 1'b0, 1'b0, 1'b0, RB ? 40 : 22, 5);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NW; i++) begin
        w[i]  = word_t'($urandom);
        st[i] = int'($urandom_range(0, 3));
      end
      run_load(w, st, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), -1, 10 + n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
